// File: rtl/mt6835_angle_reader.sv
// SPI mode-3 burst reader for the MT6835 encoder: sends 0xA003, shifts in a
// 32-bit angle/status/CRC word, checks CRC-8 (poly 0x07) and publishes the angle.
module mt6835_angle_reader #(
  parameter int CLK_DIV     = 8,
  parameter int ANGLE_W     = 21,
  parameter int CS_IDLE     = 4,
  parameter int AUTO_PERIOD = 0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  output logic               o_busy,
  output logic               spi_clk,
  output logic               spi_mosi,
  output logic               spi_cs,
  input  logic               spi_miso,
  output logic [ANGLE_W-1:0] o_angle,
  output logic [2:0]         o_status,
  output logic               o_valid,
  output logic               o_crc_err,
  output logic [15:0]        o_err_cnt
);

  localparam logic [15:0] CMD = 16'hA003;
  localparam int CNT_MAX = (CLK_DIV > CS_IDLE) ? CLK_DIV : CS_IDLE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((CS_IDLE > 1) ? CS_IDLE - 2 : 0);
  localparam int AUTO_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [AUTO_W-1:0] AUTO_LOAD = AUTO_W'((AUTO_PERIOD > 0) ? AUTO_PERIOD - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_CHECK, S_GAP
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [5:0]         r_bit;
  logic               r_phase;
  logic               r_sck;
  logic               r_mosi;
  logic               r_cs;
  logic [31:0]        r_rx;
  logic [7:0]         r_crc;
  logic [ANGLE_W-1:0] r_angle;
  logic [2:0]         r_status;
  logic               r_valid;
  logic               r_crc_err;
  logic [15:0]        r_err_cnt;
  logic [AUTO_W-1:0]  r_auto;
  logic               r_pend;

  logic       w_tick;
  logic       w_auto_exp;
  logic       w_go;
  logic       w_last_bit;
  logic       w_hold_done;
  logic       w_crc_fb;
  logic [7:0] w_crc_next;
  logic [5:0] w_next_bit;
  logic       w_mosi_next;

  assign w_tick      = (r_cnt == DIV_LAST);
  assign w_auto_exp  = (AUTO_PERIOD > 0) && (r_auto == '0);
  assign w_go        = (r_state == S_IDLE) && (i_start || r_pend || w_auto_exp);
  assign w_last_bit  = (r_bit == 6'd47);
  assign w_hold_done = (r_state == S_HOLD) && w_tick;
  assign w_crc_fb    = r_crc[7] ^ spi_miso;
  assign w_crc_next  = {r_crc[6:0], 1'b0} ^ (w_crc_fb ? 8'h07 : 8'h00);
  assign w_next_bit  = r_bit + 6'd1;
  assign w_mosi_next = (w_next_bit < 6'd16) ? CMD[4'd15 - w_next_bit[3:0]] : 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    // NOTE: default first so every path assigns w_next and no latch is inferred.
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_go) w_next = S_SETUP;
      S_SETUP: if (w_tick) w_next = S_SHIFT;
      S_SHIFT: if (w_tick && r_phase && w_last_bit) w_next = S_HOLD;
      S_HOLD:  if (w_tick) w_next = S_CHECK;
      S_CHECK: w_next = (CS_IDLE > 1) ? S_GAP : S_IDLE;
      S_GAP:   if (r_cnt == GAP_LAST) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // SPI pins, bit sequencing and the bit-serial CRC over rx[31:8].
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
      r_cnt   <= '0;
      r_bit   <= '0;
      r_phase <= 1'b0;
      r_sck   <= 1'b1;
      r_mosi  <= 1'b1;
      r_cs    <= 1'b1;
      r_rx    <= '0;
      r_crc   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_go) begin
            r_cs    <= 1'b0;
            r_bit   <= '0;
            r_phase <= 1'b0;
            r_crc   <= '0;
            r_rx    <= '0;
          end
        end
        S_SETUP: begin
          r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
          if (w_tick) begin
            r_sck  <= 1'b0;
            r_mosi <= CMD[15];
          end
        end
        S_SHIFT: begin
          r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
          if (w_tick) begin
            if (!r_phase) begin
              r_sck   <= 1'b1;
              r_phase <= 1'b1;
              if (r_bit >= 6'd16) r_rx <= {r_rx[30:0], spi_miso};
              if (r_bit >= 6'd16 && r_bit < 6'd40) r_crc <= w_crc_next;
            end else begin
              r_phase <= 1'b0;
              if (!w_last_bit) begin
                r_bit  <= w_next_bit;
                r_sck  <= 1'b0;
                r_mosi <= w_mosi_next;
              end
            end
          end
        end
        S_HOLD: begin
          r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
          if (w_tick) r_cs <= 1'b1;
        end
        S_CHECK: r_cnt <= '0;
        S_GAP:   r_cnt <= r_cnt + 1'b1;
        default: r_cnt <= '0;
      endcase
    end
  end

  // Results are registered on the HOLD->CHECK edge so they appear in the CHECK cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_angle   <= '0;
      r_status  <= '0;
      r_valid   <= 1'b0;
      r_crc_err <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_valid   <= 1'b0;
      r_crc_err <= 1'b0;
      if (w_hold_done) begin
        if (r_crc == r_rx[7:0]) begin
          r_angle  <= r_rx[31 -: ANGLE_W];
          r_status <= r_rx[10:8];
          r_valid  <= 1'b1;
        end else begin
          r_crc_err <= 1'b1;
          if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
        end
      end
    end
  end

  // Start-to-start auto trigger; an expiry while a frame runs is held as one pending request.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_auto <= '0;
      r_pend <= 1'b0;
    end else if (AUTO_PERIOD > 0) begin
      if (w_go) begin
        r_auto <= AUTO_LOAD;
        r_pend <= 1'b0;
      end else if (w_auto_exp) begin
        r_auto <= AUTO_LOAD;
        r_pend <= 1'b1;
      end else begin
        r_auto <= r_auto - 1'b1;
      end
    end
  end

  assign o_busy    = (r_state != S_IDLE);
  assign spi_clk   = r_sck;
  assign spi_mosi  = r_mosi;
  assign spi_cs    = r_cs;
  assign o_angle   = r_angle;
  assign o_status  = r_status;
  assign o_valid   = r_valid;
  assign o_crc_err = r_crc_err;
  assign o_err_cnt = r_err_cnt;

endmodule

// File: tb/tb_mt6835_angle_reader.sv
// Scoreboard bench for mt6835_angle_reader: encoder models drive MISO, expected
// results are queued at stimulus time and checked by monitors on o_valid/o_crc_err.
module tb_mt6835_angle_reader;

  localparam int CD        = 2;
  localparam int CS_LOW    = 98 * CD;
  localparam int VALID_AT  = 98 * CD + 1;
  localparam int IDLE_AT   = 98 * CD + 1 + 4;

  typedef struct {
    logic        is_err;
    logic [20:0] angle;
    logic [2:0]  status;
    logic [15:0] err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_a_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // DUT A: full width, on demand
  logic        start_a = 1'b0, a_busy, a_sck, a_mosi, a_cs, a_miso = 1'b1, a_valid, a_crc_err;
  logic [20:0] a_angle;
  logic [2:0]  a_status;
  logic [15:0] a_err;
  // DUT B: 16-bit angle
  logic        start_b = 1'b0, b_busy, b_sck, b_mosi, b_cs, b_miso = 1'b1, b_valid, b_crc_err;
  logic [15:0] b_angle;
  logic [2:0]  b_status;
  logic [15:0] b_err;
  // DUT C/D: auto trigger 300 and 100
  logic        c_busy, c_sck, c_mosi, c_cs, c_valid, c_crc_err;
  logic        d_busy, d_sck, d_mosi, d_cs, d_valid, d_crc_err;
  logic [20:0] c_angle, d_angle;
  logic [2:0]  c_status, d_status;
  logic [15:0] c_err, d_err;

  mt6835_angle_reader #(.CLK_DIV(CD), .ANGLE_W(21), .CS_IDLE(4), .AUTO_PERIOD(0)) dut_a (
    .i_clk(clk), .i_rst_n(rst_a_n), .i_start(start_a), .o_busy(a_busy), .spi_clk(a_sck),
    .spi_mosi(a_mosi), .spi_cs(a_cs), .spi_miso(a_miso), .o_angle(a_angle), .o_status(a_status),
    .o_valid(a_valid), .o_crc_err(a_crc_err), .o_err_cnt(a_err));

  mt6835_angle_reader #(.CLK_DIV(CD), .ANGLE_W(16), .CS_IDLE(4), .AUTO_PERIOD(0)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b), .o_busy(b_busy), .spi_clk(b_sck),
    .spi_mosi(b_mosi), .spi_cs(b_cs), .spi_miso(b_miso), .o_angle(b_angle), .o_status(b_status),
    .o_valid(b_valid), .o_crc_err(b_crc_err), .o_err_cnt(b_err));

  mt6835_angle_reader #(.CLK_DIV(CD), .ANGLE_W(21), .CS_IDLE(4), .AUTO_PERIOD(300)) dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(1'b0), .o_busy(c_busy), .spi_clk(c_sck),
    .spi_mosi(c_mosi), .spi_cs(c_cs), .spi_miso(1'b0), .o_angle(c_angle), .o_status(c_status),
    .o_valid(c_valid), .o_crc_err(c_crc_err), .o_err_cnt(c_err));

  mt6835_angle_reader #(.CLK_DIV(CD), .ANGLE_W(21), .CS_IDLE(4), .AUTO_PERIOD(100)) dut_d (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(1'b0), .o_busy(d_busy), .spi_clk(d_sck),
    .spi_mosi(d_mosi), .spi_cs(d_cs), .spi_miso(1'b0), .o_angle(d_angle), .o_status(d_status),
    .o_valid(d_valid), .o_crc_err(d_crc_err), .o_err_cnt(d_err));

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // CRC-8/0x07 as polynomial long division of {data, 8'h00}
  function automatic logic [7:0] crc8(input logic [23:0] d);
    logic [31:0] r;
    r = {d, 8'h00};
    for (int i = 31; i >= 8; i--)
      if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
    return r[7:0];
  endfunction

  // Encoder models: MISO changes on SCK fall (from fall 16 on), MOSI captured on SCK rise
  logic [31:0] frm_a = '0, tx_a = '0, frm_b = '0, tx_b = '0;
  logic [47:0] mosi_a = '0;
  int fcnt_a = 0, rcnt_a = 0, nf_a = 0, ffall_a = 0, fcnt_b = 0;

  always @(negedge a_cs) begin tx_a = frm_a; fcnt_a = 0; rcnt_a = 0; nf_a++; end
  always @(negedge a_sck) if (!a_cs) begin
    if (fcnt_a == 0) ffall_a = cyc;
    if (fcnt_a >= 16 && fcnt_a < 48) a_miso = tx_a[47 - fcnt_a];
    fcnt_a++;
  end
  always @(posedge a_sck) if (!a_cs) begin
    if (rcnt_a < 48) mosi_a[47 - rcnt_a] = a_mosi;
    rcnt_a++;
  end
  always @(negedge b_cs) begin tx_b = frm_b; fcnt_b = 0; end
  always @(negedge b_sck) if (!b_cs) begin
    if (fcnt_b >= 16 && fcnt_b < 48) b_miso = tx_b[47 - fcnt_b];
    fcnt_b++;
  end

  // Scoreboards and monitors
  exp_t q_a[$], q_b[$];
  logic [20:0] ea_angle = '0;
  logic [2:0]  ea_status = '0;
  logic [15:0] ea_err = '0;
  int lowcnt_a = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst_a_n && (a_valid || a_crc_err)) begin
      if (q_a.size() == 0) check("a_spurious_event", {62'd0, a_valid, a_crc_err}, 64'd0);
      else begin
        e = q_a.pop_front();
        check("a_valid", a_valid, !e.is_err);
        check("a_crc_err", a_crc_err, e.is_err);
        check("a_angle", a_angle, e.angle);
        check("a_status", a_status, e.status);
        check("a_err_cnt", a_err, e.err);
        check("a_event_cycle", cyc, e.cyc);
      end
    end
    if (!rst_a_n) lowcnt_a = 0;
    else if (!a_cs) lowcnt_a++;
    else begin
      if (lowcnt_a != 0) check("a_cs_low_cycles", lowcnt_a, CS_LOW);
      lowcnt_a = 0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (b_valid || b_crc_err)) begin
      if (q_b.size() == 0) check("b_spurious_event", {62'd0, b_valid, b_crc_err}, 64'd0);
      else begin
        e = q_b.pop_front();
        check("b_valid", b_valid, !e.is_err);
        check("b_angle", b_angle, e.angle[15:0]);
        check("b_status", b_status, e.status);
        check("b_event_cycle", cyc, e.cyc);
      end
    end
  end

  // Auto-trigger monitors: CS fall-to-fall spacing
  logic prev_c = 1'b1, prev_d = 1'b1;
  int last_c = 0, last_d = 0, nf_c = 0, nf_d = 0;
  always @(negedge clk) begin
    if (rst_n && prev_c && !c_cs) begin
      if (nf_c >= 1 && nf_c <= 3) check("c_cs_period", cyc - last_c, 300);
      last_c = cyc;
      nf_c++;
    end
    if (rst_n && prev_d && !d_cs) begin
      if (nf_d >= 1 && nf_d <= 4) check("d_cs_period", cyc - last_d, IDLE_AT);
      last_d = cyc;
      nf_d++;
    end
    prev_c = c_cs;
    prev_d = d_cs;
  end

  task automatic frame_a(input logic [20:0] ang, input logic [2:0] st, input logic flip,
                         input logic poke);
    exp_t e;
    int t0, nf0;
    frm_a = {ang, st, crc8({ang, st}) ^ {7'd0, flip}};
    if (!flip) begin ea_angle = ang; ea_status = st; end
    else if (ea_err != 16'hFFFF) ea_err++;
    e.is_err = flip; e.angle = ea_angle; e.status = ea_status; e.err = ea_err;
    @(negedge clk);
    t0 = cyc; e.cyc = t0 + VALID_AT; q_a.push_back(e); nf0 = nf_a;
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    if (poke) begin
      repeat (60) @(negedge clk);
      check("a_busy_mid_frame", a_busy, 1'b1);
      start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    end
    for (int i = 0; i < 400 && a_busy; i++) @(negedge clk);
    check("a_busy_fall_cycle", cyc - t0, IDLE_AT);
    check("a_first_sck_fall", ffall_a - t0, 1 + CD);
    check("a_mosi_stream", mosi_a, {16'hA003, 32'hFFFF_FFFF});
    if (poke) begin
      repeat (20) @(negedge clk);
      check("a_no_extra_frame", nf_a - nf0, 1);
      check("a_idle_after_poke", a_busy, 1'b0);
    end
  endtask

  task automatic frame_b(input logic [20:0] ang, input logic [2:0] st, input logic [15:0] exp_ang);
    exp_t e;
    int t0;
    frm_b = {ang, st, crc8({ang, st})};
    e.is_err = 1'b0; e.angle = {5'd0, exp_ang}; e.status = st; e.err = '0;
    @(negedge clk);
    t0 = cyc; e.cyc = t0 + VALID_AT; q_b.push_back(e);
    start_b = 1'b1; @(negedge clk); start_b = 1'b0;
    for (int i = 0; i < 400 && b_busy; i++) @(negedge clk);
    check("b_busy_fall_cycle", cyc - t0, IDLE_AT);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_cs", a_cs, 1'b1);
    check("rst_sck", a_sck, 1'b1);
    check("rst_mosi", a_mosi, 1'b1);
    check("rst_busy", a_busy, 1'b0);
    check("rst_angle", a_angle, 21'd0);
    check("rst_err_cnt", a_err, 16'd0);
    rst_n = 1'b1; rst_a_n = 1'b1;
    repeat (2) @(negedge clk);

    frame_a(21'h12345, 3'b000, 1'b0, 1'b0);   // good frame
    frame_a(21'h12345, 3'b000, 1'b1, 1'b0);   // CRC bit 0 flipped
    frame_a(21'h0ABCD, 3'b010, 1'b0, 1'b1);   // start pulsed during SHIFT

    @(negedge clk);
    force dut_a.r_err_cnt = 16'hFFFE;
    @(negedge clk);
    release dut_a.r_err_cnt;
    ea_err = 16'hFFFE;
    @(negedge clk);
    check("a_err_preload", a_err, 16'hFFFE);
    frame_a(21'h00777, 3'b001, 1'b1, 1'b0);   // reaches 0xFFFF
    frame_a(21'h00777, 3'b001, 1'b1, 1'b0);   // stays 0xFFFF

    // Reset at SCK falling edge 20 of a frame in flight
    frm_a = {21'h12345, 3'b000, crc8({21'h12345, 3'b000})};
    @(negedge clk);
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    for (int i = 0; i < 300 && !(!a_cs && fcnt_a >= 21); i++) @(negedge clk);
    check("a_rst_edge_reached", fcnt_a, 21);
    rst_a_n = 1'b0;
    #1;
    check("midrst_cs", a_cs, 1'b1);
    check("midrst_sck", a_sck, 1'b1);
    check("midrst_mosi", a_mosi, 1'b1);
    check("midrst_busy", a_busy, 1'b0);
    check("midrst_valid", {a_valid, a_crc_err}, 2'b00);
    check("midrst_angle", a_angle, 21'd0);
    check("midrst_status", a_status, 3'd0);
    check("midrst_err_cnt", a_err, 16'd0);
    q_a.delete();
    ea_angle = '0; ea_status = '0; ea_err = '0;
    repeat (3) @(negedge clk);
    rst_a_n = 1'b1;
    repeat (2) @(negedge clk);
    frame_a(21'h12345, 3'b000, 1'b0, 1'b0);   // clean frame after reset

    frame_b(21'h1FFFFF, 3'b000, 16'hFFFF);
    frame_b(21'h00001F, 3'b101, 16'h0000);

    repeat (10) @(negedge clk);
    check("a_queue_drained", q_a.size(), 0);
    check("b_queue_drained", q_b.size(), 0);
    check("c_frames_seen", nf_c >= 4, 1'b1);
    check("d_frames_seen", nf_d >= 5, 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
